axis32_rx_pkt_fifo: RTL and testbench

Store-and-forward receive packet FIFO that sits directly downstream of the 32-bit XGMII-to-AXIS receive converter. It accepts that converter's non-backpressurable AXIS stream (`tdata`/`tvldb`/`tvalid`/`tlast`/`tuser`), buffers each frame in full, and commits only frames whose FCS check passed. It discards bad-FCS frames and frames that overflow the buffer. Committed frames are replayed on a standard AXIS master with `tready` backpressure toward the user logic.

---
 rtl/axis32_rx_pkt_fifo_pkg.sv | 22 ++
 rtl/axis32_rx_pkt_fifo_sdp_ram.sv | 28 ++
 rtl/axis32_rx_pkt_fifo.sv | 194 +++++++++++++++++++
 tb/tb_axis32_rx_pkt_fifo.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis32_rx_pkt_fifo_pkg.sv
// Shared definitions for the receive packet FIFO: write-FSM state encoding and
// the layout of a stored 35-bit word {tlast, tvldb[1:0], tdata[31:0]}.
// No ports; imported by the FIFO top and its RAM wrapper users.
package axis32_rx_pkt_fifo_pkg;

   typedef enum logic [2:0] {
      WR_IDLE  = 3'b001,
      WR_FRAME = 3'b010,
      WR_DROP  = 3'b100
   } wr_state_t;

   localparam int TLAST_BIT  = 34;
   localparam int TVLDB_LSB  = 32;
   localparam int WORD_WIDTH = 35;

   function automatic logic [WORD_WIDTH-1:0] pack_word(input logic        last,
                                                        input logic [1:0]  vldb,
                                                        input logic [31:0] data);
      return {last, vldb, data};
   endfunction

endpackage

// File: rtl/axis32_rx_pkt_fifo_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with registered output.
// Ports: clk, wr_en/wr_addr/wr_data (write), rd_en/rd_addr -> rd_data one cycle later.
// Read data holds its last value when rd_en is low; no reset on the array.
module axis32_rx_pkt_fifo_sdp_ram #(
   parameter int DATA_WIDTH = 35,
   parameter int ADDR_WIDTH = 9
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/axis32_rx_pkt_fifo.sv
// Store-and-forward RX packet FIFO: buffers whole frames, commits good-FCS frames, drops bad/overflowing ones.
// Latency: first word of a committed frame is on m_tvalid_o in the cycle after edge N+2 (last beat at edge N).
// Backpressure: none toward the upstream converter; m_tready_i stalls the output, which holds stable while stalled.
// Ports: clk_i, rst_i (async, active-high); s_t* input stream (no ready); m_t* AXIS master output;
//        good_frames_o / bad_frames_o / ovf_frames_o wrapping 32-bit frame counters.
module axis32_rx_pkt_fifo
   import axis32_rx_pkt_fifo_pkg::*;
#(
   parameter int ADDR_WIDTH = 9
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] s_tdata_i,
   input  logic [1:0]  s_tvldb_i,
   input  logic        s_tvalid_i,
   input  logic        s_tlast_i,
   input  logic        s_tuser_i,
   output logic [31:0] m_tdata_o,
   output logic [1:0]  m_tvldb_o,
   output logic        m_tvalid_o,
   output logic        m_tlast_o,
   input  logic        m_tready_i,
   output logic [31:0] good_frames_o,
   output logic [31:0] bad_frames_o,
   output logic [31:0] ovf_frames_o
);

   localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

   // ---------------- write side ----------------
   wr_state_t             wr_state, wr_state_nxt;
   logic [ADDR_WIDTH:0]   wr_ptr, wr_ptr_nxt;
   logic [ADDR_WIDTH:0]   wr_commit, wr_commit_nxt;
   logic [ADDR_WIDTH:0]   rd_ptr;
   logic                  full;
   logic                  ram_we;
   logic                  inc_good, inc_bad, inc_ovf;

   // Occupancy is measured against the registered rd_ptr, so a read in this
   // cycle only frees its slot for the following cycle.
   assign full = ((wr_ptr - rd_ptr) == DEPTH);

   always_comb begin
      wr_state_nxt  = wr_state;
      wr_ptr_nxt    = wr_ptr;
      wr_commit_nxt = wr_commit;
      ram_we        = 1'b0;
      inc_good      = 1'b0;
      inc_bad       = 1'b0;
      inc_ovf       = 1'b0;
      if (s_tvalid_i) begin
         case (wr_state)
            WR_IDLE, WR_FRAME: begin
               if (full) begin
                  // Overflow wins over FCS status: the frame is lost either way.
                  if (s_tlast_i) begin
                     wr_ptr_nxt   = wr_commit;
                     inc_ovf      = 1'b1;
                     wr_state_nxt = WR_IDLE;
                  end else begin
                     wr_state_nxt = WR_DROP;
                  end
               end else if (!s_tlast_i) begin
                  ram_we       = 1'b1;
                  wr_ptr_nxt   = wr_ptr + 1'b1;
                  wr_state_nxt = WR_FRAME;
               end else if (s_tuser_i) begin
                  ram_we        = 1'b1;
                  wr_ptr_nxt    = wr_ptr + 1'b1;
                  wr_commit_nxt = wr_ptr + 1'b1;
                  inc_good      = 1'b1;
                  wr_state_nxt  = WR_IDLE;
               end else begin
                  wr_ptr_nxt   = wr_commit;
                  inc_bad      = 1'b1;
                  wr_state_nxt = WR_IDLE;
               end
            end
            WR_DROP: begin
               if (s_tlast_i) begin
                  wr_ptr_nxt   = wr_commit;
                  inc_ovf      = 1'b1;
                  wr_state_nxt = WR_IDLE;
               end
            end
            default: begin
               wr_ptr_nxt   = wr_commit;
               wr_state_nxt = WR_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_state  <= WR_IDLE;
         wr_ptr    <= '0;
         wr_commit <= '0;
      end else begin
         wr_state  <= wr_state_nxt;
         wr_ptr    <= wr_ptr_nxt;
         wr_commit <= wr_commit_nxt;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         good_frames_o <= '0;
         bad_frames_o  <= '0;
         ovf_frames_o  <= '0;
      end else begin
         if (inc_good) good_frames_o <= good_frames_o + 32'd1;
         if (inc_bad)  bad_frames_o  <= bad_frames_o + 32'd1;
         if (inc_ovf)  ovf_frames_o  <= ovf_frames_o + 32'd1;
      end
   end

   // ---------------- storage ----------------
   logic                  rd_en;
   logic [WORD_WIDTH-1:0] ram_q;

   axis32_rx_pkt_fifo_sdp_ram #(
      .DATA_WIDTH (WORD_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk     (clk_i),
      .wr_en   (ram_we),
      .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
      .wr_data (pack_word(s_tlast_i, s_tvldb_i, s_tdata_i)),
      .rd_en   (rd_en),
      .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
      .rd_data (ram_q)
   );

   // ---------------- read side ----------------
   // ram_vld marks a read issued last cycle whose data is now on ram_q.
   // out_* is the visible output register, skid_* the second entry.
   logic                  ram_vld;
   logic                  out_vld, skid_vld;
   logic [WORD_WIDTH-1:0] out_dat, skid_dat;
   logic                  pop;
   logic                  empty;
   logic [1:0]            inflight;

   assign empty = (rd_ptr == wr_commit);
   assign pop   = out_vld & m_tready_i;

   // Words already pulled out of the RAM and not yet consumed after this
   // cycle's pop. Issuing only while this is below 2 guarantees the word read
   // now always finds a free output entry when it lands, while still letting
   // one read per cycle through when the consumer keeps up.
   assign inflight = 2'(out_vld) + 2'(skid_vld) + 2'(ram_vld) - 2'(pop);
   assign rd_en    = !empty && (inflight < 2'd2);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_ptr   <= '0;
         ram_vld  <= 1'b0;
         out_vld  <= 1'b0;
         out_dat  <= '0;
         skid_vld <= 1'b0;
         skid_dat <= '0;
      end else begin
         if (rd_en) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         ram_vld <= rd_en;
         if (pop) begin
            if (skid_vld) begin
               out_dat  <= skid_dat;
               skid_vld <= ram_vld;
               if (ram_vld) skid_dat <= ram_q;
            end else begin
               out_vld <= ram_vld;
               if (ram_vld) out_dat <= ram_q;
            end
         end else if (ram_vld) begin
            if (!out_vld) begin
               out_vld <= 1'b1;
               out_dat <= ram_q;
            end else begin
               skid_vld <= 1'b1;
               skid_dat <= ram_q;
            end
         end
      end
   end

   assign m_tvalid_o = out_vld;
   assign m_tdata_o  = out_dat[31:0];
   assign m_tvldb_o  = out_dat[TVLDB_LSB +: 2];
   assign m_tlast_o  = out_dat[TLAST_BIT];

endmodule

// File: tb/tb_axis32_rx_pkt_fifo.sv
// Bench for axis32_rx_pkt_fifo with a 16-word buffer: directed frame scenarios plus
// randomized traffic against a frame-level model (expected beat queue + occupancy bound).
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_axis32_rx_pkt_fifo;

   localparam int AW    = 4;
   localparam int DEPTH = 16;

   localparam int C_GOOD   = 0;
   localparam int C_BAD    = 1;
   localparam int C_OVF    = 2;
   localparam int C_UNSURE = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] s_tdata = '0;
   logic [1:0]  s_tvldb = '0;
   logic        s_tvalid = 1'b0;
   logic        s_tlast = 1'b0;
   logic        s_tuser = 1'b0;
   logic [31:0] m_tdata;
   logic [1:0]  m_tvldb;
   logic        m_tvalid;
   logic        m_tlast;
   logic        m_tready = 1'b0;
   logic [31:0] good_frames, bad_frames, ovf_frames;

   int checks = 0;
   int errors = 0;

   logic [34:0] exp_q[$];
   int committed_words = 0;
   int popped_words    = 0;
   int exp_good = 0, exp_bad = 0, exp_ovf = 0;
   int rmode = 0;   // 0: ready low, 1: ready high, 2: toggle, 3: random

   axis32_rx_pkt_fifo #(.ADDR_WIDTH(AW)) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .s_tdata_i     (s_tdata),
      .s_tvldb_i     (s_tvldb),
      .s_tvalid_i    (s_tvalid),
      .s_tlast_i     (s_tlast),
      .s_tuser_i     (s_tuser),
      .m_tdata_o     (m_tdata),
      .m_tvldb_o     (m_tvldb),
      .m_tvalid_o    (m_tvalid),
      .m_tlast_o     (m_tlast),
      .m_tready_i    (m_tready),
      .good_frames_o (good_frames),
      .bad_frames_o  (bad_frames),
      .ovf_frames_o  (ovf_frames)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Frame outcome from the buffer-space rules. "used" is committed words not
   // yet seen leaving the output, an upper bound on the real occupancy; at most
   // two of those words can already have left the RAM without being popped.
   function automatic int classify(input int len, input bit user, input bit ready_off);
      int used;
      used = committed_words - popped_words;
      if (len > DEPTH) return C_OVF;
      if (ready_off && (len > DEPTH - used + 2)) return C_OVF;
      if (len <= DEPTH - used) return user ? C_GOOD : C_BAD;
      return C_UNSURE;
   endfunction

   task automatic clear_model();
      exp_q.delete();
      committed_words = 0;
      popped_words    = 0;
      exp_good = 0;
      exp_bad  = 0;
      exp_ovf  = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_model();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic send_beat(input logic [31:0] d, input logic [1:0] vb,
                            input logic last, input logic user);
      s_tdata  = d;
      s_tvldb  = vb;
      s_tlast  = last;
      s_tuser  = user;
      s_tvalid = 1'b1;
      @(posedge clk);
      #1;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      s_tuser  = 1'b0;
   endtask

   task automatic send_frame(input int len, input bit user, input logic [1:0] last_vb,
                             input bit ready_off, output int cls);
      logic [34:0] words[$];
      logic [31:0] d;
      logic [1:0]  vb;
      logic        last;
      cls = classify(len, user, ready_off);
      for (int i = 0; i < len; i++) begin
         d    = $urandom;
         last = (i == len - 1);
         vb   = last ? last_vb : 2'd3;
         words.push_back({last, vb, d});
         send_beat(d, vb, last, user);
      end
      case (cls)
         C_GOOD: begin
            foreach (words[k]) exp_q.push_back(words[k]);
            committed_words += len;
            exp_good++;
         end
         C_BAD:   exp_bad++;
         default: exp_ovf++;
      endcase
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || m_tvalid) && n < 400) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk({name, "_drained"}, exp_q.size(), 0);
      chk({name, "_idle"}, m_tvalid, 1'b0);
   endtask

   // Ready generator.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (rmode)
            0:       m_tready = 1'b0;
            1:       m_tready = 1'b1;
            2:       m_tready = ~m_tready;
            default: m_tready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Output compare against the expected beat queue, plus hold-while-stalled.
   initial begin
      logic        stalled;
      logic [34:0] held;
      logic [34:0] act;
      logic [34:0] req;
      stalled = 1'b0;
      held    = '0;
      forever begin
         @(negedge clk);
         act = {m_tlast, m_tvldb, m_tdata};
         if (rst) begin
            stalled = 1'b0;
         end else begin
            if (stalled) begin
               chk("hold_valid", m_tvalid, 1'b1);
               chk("hold_word", act, held);
            end
            if (m_tvalid && m_tready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_beat actual=%0h required=no_beat", act);
               end else begin
                  req = exp_q.pop_front();
                  chk("out_beat", act, req);
                  popped_words++;
               end
            end
            stalled = m_tvalid && !m_tready;
            held    = act;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          cls;
      logic [34:0] first;
      int          n;
      int          len;
      bit          user;

      // ---- reset state ----
      #1;
      chk("rst_tvalid", m_tvalid, 1'b0);
      chk("rst_tdata", m_tdata, 32'd0);
      chk("rst_tlast", m_tlast, 1'b0);
      chk("rst_tvldb", m_tvldb, 2'd0);
      chk("rst_good", good_frames, 32'd0);
      chk("rst_bad", bad_frames, 32'd0);
      chk("rst_ovf", ovf_frames, 32'd0);
      do_reset();

      // ---- 16-word good frame, commit latency ----
      rmode = 1;
      repeat (2) @(posedge clk);
      #1;
      send_frame(16, 1'b1, 2'd1, 1'b0, cls);
      first = exp_q[0];
      chk("lat_n_plus0", m_tvalid, 1'b0);
      @(posedge clk); #1;
      chk("lat_n_plus1", m_tvalid, 1'b0);
      @(posedge clk); #1;
      chk("lat_n_plus2", m_tvalid, 1'b1);
      chk("lat_first_word", m_tdata, first[31:0]);
      wait_drain("good16");
      chk("good16_good", good_frames, 32'd1);

      // ---- bad then good ----
      do_reset();
      send_frame(8, 1'b0, 2'd2, 1'b0, cls);
      send_frame(4, 1'b1, 2'd3, 1'b0, cls);
      wait_drain("badgood");
      chk("badgood_bad", bad_frames, 32'd1);
      chk("badgood_good", good_frames, 32'd1);

      // ---- overflow with ready held low ----
      do_reset();
      rmode = 0;
      @(posedge clk); #1;
      send_frame(10, 1'b1, 2'd0, 1'b1, cls);
      repeat (6) @(posedge clk);
      #1;
      send_frame(10, 1'b1, 2'd3, 1'b1, cls);
      repeat (3) @(posedge clk);
      #1;
      chk("ovf_count", ovf_frames, 32'd1);
      chk("ovf_good", good_frames, 32'd1);
      chk("ovf_hold_valid", m_tvalid, 1'b1);
      rmode = 1;
      wait_drain("ovf");

      // ---- frame longer than the buffer ----
      do_reset();
      send_frame(20, 1'b1, 2'd3, 1'b0, cls);
      wait_drain("long");
      chk("long_ovf", ovf_frames, 32'd1);
      chk("long_good", good_frames, 32'd0);

      // ---- back-to-back single-beat frames, toggling ready ----
      do_reset();
      rmode = 2;
      for (int i = 0; i < 20; i++) begin
         send_frame(1, 1'b1, 2'($urandom_range(0, 3)), 1'b0, cls);
      end
      wait_drain("b2b");
      chk("b2b_good", good_frames, 32'd20);

      // ---- randomized traffic with wrap ----
      do_reset();
      rmode = 3;
      for (int f = 0; f < 100; f++) begin
         len  = $urandom_range(1, 8);
         user = ($urandom_range(0, 9) < 8);
         n = 0;
         while (classify(len, user, 1'b0) == C_UNSURE && n < 400) begin
            @(posedge clk);
            #1;
            n++;
         end
         if (classify(len, user, 1'b0) == C_UNSURE) begin
            checks++;
            errors++;
            $display("FAIL rand_space_wait actual=no_space required=space frame=%0d", f);
         end else begin
            send_frame(len, user, 2'($urandom_range(0, 3)), 1'b0, cls);
         end
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 4)) @(posedge clk);
            #1;
         end
      end
      rmode = 1;
      wait_drain("rand");
      chk("rand_good", good_frames, 32'(exp_good));
      chk("rand_bad", bad_frames, 32'(exp_bad));
      chk("rand_ovf", ovf_frames, 32'(exp_ovf));
      chk("rand_total", 32'(good_frames + bad_frames + ovf_frames), 32'd100);

      // ---- reset in the middle of a frame ----
      do_reset();
      rmode = 0;
      @(posedge clk); #1;
      send_frame(4, 1'b1, 2'd3, 1'b0, cls);
      repeat (5) @(posedge clk);
      #1;
      chk("mid_pre_valid", m_tvalid, 1'b1);
      for (int i = 0; i < 3; i++) begin
         send_beat($urandom, 2'd3, 1'b0, 1'b1);
      end
      #2;
      rst = 1'b1;
      clear_model();
      #1;
      chk("mid_rst_valid", m_tvalid, 1'b0);
      chk("mid_rst_tdata", m_tdata, 32'd0);
      chk("mid_rst_tlast", m_tlast, 1'b0);
      chk("mid_rst_good", good_frames, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      rmode = 1;
      send_frame(6, 1'b1, 2'd2, 1'b0, cls);
      wait_drain("mid_after");
      chk("mid_after_good", good_frames, 32'd1);
      chk("mid_after_ovf", ovf_frames, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
